// File: rtl/burst_codec_pkg.sv
// burst_codec_pkg: mode/status codes, FSM states and default generator polynomial
// shared by burst_codec_seq and its LFSR divider.
package burst_codec_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'b000,
    MODE_ENCODE = 3'b001,
    MODE_DECODE = 3'b010
  } mode_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'b00,
    ST_CORR   = 2'b01,
    ST_UNCORR = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SYND,
    TRAP,
    FIX,
    DONE
  } state_e;

  // (x^15+1)(x^9+x^4+1)
  localparam logic [24:0] GPOLY_DEFAULT = 25'h1088211;

endpackage

// File: rtl/burst_codec_seq_gf2_lfsr_div.sv
// gf2_lfsr_div: serial GF(2) divider by GPOLY. Supports plain division, division of
// the input premultiplied by x^R (systematic encoding), and a multiply-by-x^(-1) step.
module gf2_lfsr_div
  import burst_codec_pkg::*;
#(
  parameter int unsigned R     = 24,
  parameter logic [R:0]  GPOLY = GPOLY_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift,
  input  logic         premul,
  input  logic         bit_in,
  input  logic         inv_step,
  output logic [R-1:0] rem
);

  logic [R-1:0] rem_q, rem_d;
  logic [R-1:0] folded;
  logic         fb;

  always_comb begin
    rem_d  = rem_q;
    fb     = 1'b0;
    folded = '0;
    if (clear) begin
      rem_d = '0;
    end else if (shift) begin
      fb    = rem_q[R-1] ^ (premul & bit_in);
      rem_d = {rem_q[R-2:0], bit_in & ~premul} ^ (fb ? GPOLY[R-1:0] : '0);
    end else if (inv_step) begin
      // Adding g when bit 0 is set makes the value divisible by x; g's x^R term
      // lands in the top bit after the right shift.
      folded = rem_q ^ (rem_q[0] ? GPOLY[R-1:0] : '0);
      rem_d  = {rem_q[0], folded[R-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) rem_q <= '0;
    else      rem_q <= rem_d;
  end

  assign rem = rem_q;

endmodule

// File: rtl/burst_codec_seq.sv
// burst_codec_seq: handshaked sequential Fire-code encoder / error-trapping decoder.
// Optional macro BURST_CODEC_STATS_EN adds saturating corr_cnt / uncorr_cnt outputs.
module burst_codec_seq
  import burst_codec_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned K     = 40,
  parameter int unsigned B     = 8,
  parameter logic [N-K:0] GPOLY = GPOLY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           mode,
  input  logic                 start,
  input  logic [N-1:0]         data_in,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         data_out,
  output logic [1:0]           status,
  output logic [$clog2(N)-1:0] burst_pos
`ifdef BURST_CODEC_STATS_EN
  ,
  output logic [15:0]          corr_cnt,
  output logic [15:0]          uncorr_cnt
`endif
);

  localparam int unsigned   R      = N - K;
  localparam int unsigned   PW     = $clog2(N);
  localparam logic [PW-1:0] K_LAST = PW'(K - 1);
  localparam logic [PW-1:0] N_LAST = PW'(N - 1);

  state_e         state_q, state_d;
  logic [PW-1:0]  cnt_q, cnt_d;
  logic           is_dec_q, is_dec_d;
  logic [N-1:0]   cw_q, cw_d;
  logic           hit_q, hit_d;
  logic [PW-1:0]  hit_pos_q, hit_pos_d;
  logic [B-1:0]   hit_pat_q, hit_pat_d;
  logic [N-1:0]   res_data_q, res_data_d;
  logic [1:0]     res_status_q, res_status_d;
  logic [PW-1:0]  res_pos_q, res_pos_d;
  logic [N-1:0]   data_out_q, data_out_d;
  logic [1:0]     status_q, status_d;
  logic [PW-1:0]  burst_pos_q, burst_pos_d;
  logic           done_q, done_d;

  logic           div_clear, div_shift, div_premul, div_bit, div_inv;
  logic [R-1:0]   rem;
  logic [PW-1:0]  sel;
  logic           accept;
  logic [N+B-1:0] burst_wide;
  logic [N-1:0]   fixed_cw;

  gf2_lfsr_div #(
    .R     (R),
    .GPOLY (GPOLY)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .clear    (div_clear),
    .shift    (div_shift),
    .premul   (div_premul),
    .bit_in   (div_bit),
    .inv_step (div_inv),
    .rem      (rem)
  );

  assign accept     = start && (mode == MODE_ENCODE || mode == MODE_DECODE);
  // Bits shifted beyond N mean the trapped burst does not lie inside the codeword.
  assign burst_wide = {{N{1'b0}}, hit_pat_q} << hit_pos_q;
  assign fixed_cw   = cw_q ^ burst_wide[N-1:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_dec_d     = is_dec_q;
    cw_d         = cw_q;
    hit_d        = hit_q;
    hit_pos_d    = hit_pos_q;
    hit_pat_d    = hit_pat_q;
    res_data_d   = res_data_q;
    res_status_d = res_status_q;
    res_pos_d    = res_pos_q;
    data_out_d   = data_out_q;
    status_d     = status_q;
    burst_pos_d  = burst_pos_q;
    done_d       = 1'b0;
    div_clear    = 1'b0;
    div_shift    = 1'b0;
    div_premul   = 1'b0;
    div_bit      = 1'b0;
    div_inv      = 1'b0;
    sel          = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          is_dec_d  = (mode == MODE_DECODE);
          cw_d      = data_in;
          cnt_d     = '0;
          hit_d     = 1'b0;
          hit_pos_d = '0;
          hit_pat_d = '0;
          div_clear = 1'b1;
          state_d   = (mode == MODE_DECODE) ? SYND : SHIFT;
        end
      end
      SHIFT: begin
        sel        = K_LAST - cnt_q;
        div_shift  = 1'b1;
        div_premul = 1'b1;
        div_bit    = cw_q[sel];
        cnt_d      = cnt_q + PW'(1);
        if (cnt_q == K_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      SYND: begin
        sel       = N_LAST - cnt_q;
        div_shift = 1'b1;
        div_bit   = cw_q[sel];
        cnt_d     = cnt_q + PW'(1);
        if (cnt_q == N_LAST) begin
          cnt_d   = '0;
          state_d = TRAP;
        end
      end
      TRAP: begin
        div_inv = 1'b1;
        if (!hit_q && (rem >> B) == '0) begin
          hit_d     = 1'b1;
          hit_pos_d = cnt_q;
          hit_pat_d = rem[B-1:0];
        end
        cnt_d = cnt_q + PW'(1);
        if (cnt_q == N_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        // A zero syndrome always traps at j=0 with an all-zero pattern.
        if (hit_q && hit_pat_q == '0) begin
          res_data_d   = {{R{1'b0}}, cw_q[N-1:R]};
          res_status_d = ST_OK;
          res_pos_d    = '0;
        end else if (hit_q && burst_wide[N+B-1:N] == '0) begin
          res_data_d   = {{R{1'b0}}, fixed_cw[N-1:R]};
          res_status_d = ST_CORR;
          res_pos_d    = hit_pos_q;
        end else begin
          res_data_d   = {{R{1'b0}}, cw_q[N-1:R]};
          res_status_d = ST_UNCORR;
          res_pos_d    = '0;
        end
        state_d = DONE;
      end
      DONE: begin
        done_d = 1'b1;
        if (is_dec_q) begin
          data_out_d  = res_data_q;
          status_d    = res_status_q;
          burst_pos_d = res_pos_q;
        end else begin
          data_out_d  = {cw_q[K-1:0], rem};
          status_d    = ST_OK;
          burst_pos_d = '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_dec_q     <= 1'b0;
      cw_q         <= '0;
      hit_q        <= 1'b0;
      hit_pos_q    <= '0;
      hit_pat_q    <= '0;
      res_data_q   <= '0;
      res_status_q <= '0;
      res_pos_q    <= '0;
      data_out_q   <= '0;
      status_q     <= '0;
      burst_pos_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_dec_q     <= is_dec_d;
      cw_q         <= cw_d;
      hit_q        <= hit_d;
      hit_pos_q    <= hit_pos_d;
      hit_pat_q    <= hit_pat_d;
      res_data_q   <= res_data_d;
      res_status_q <= res_status_d;
      res_pos_q    <= res_pos_d;
      data_out_q   <= data_out_d;
      status_q     <= status_d;
      burst_pos_q  <= burst_pos_d;
      done_q       <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign data_out  = data_out_q;
  assign status    = status_q;
  assign burst_pos = burst_pos_q;

`ifdef BURST_CODEC_STATS_EN
  logic [15:0] corr_cnt_q, corr_cnt_d;
  logic [15:0] uncorr_cnt_q, uncorr_cnt_d;

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (state_q == DONE && is_dec_q) begin
      if (res_status_q == ST_CORR && corr_cnt_q != '1)
        corr_cnt_d = corr_cnt_q + 16'd1;
      if (res_status_q == ST_UNCORR && uncorr_cnt_q != '1)
        uncorr_cnt_d = uncorr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_burst_codec_seq.sv
// Self-checking bench for burst_codec_seq against a polynomial-arithmetic reference model.
module tb_burst_codec_seq;

  localparam int N = 64;
  localparam int K = 40;
  localparam int B = 8;
  localparam logic [24:0] G = 25'h1088211;
  localparam int ENC_LAT = K + 1;
  localparam int DEC_LAT = 2 * N + 2;
  localparam int TMO = 400;
  localparam logic [39:0] MSG0 = 40'hDD5486AA91;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic        start = 1'b0;
  logic [63:0] data_in = '0;
  logic        busy, done;
  logic [63:0] data_out;
  logic [1:0]  status;
  logic [5:0]  burst_pos;
`ifdef BURST_CODEC_STATS_EN
  logic [15:0] corr_cnt, uncorr_cnt;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned m_corr = 0;
  int unsigned m_uncorr = 0;
  logic [23:0] pw [0:71];
  logic [63:0] cw_golden;

  burst_codec_seq #(.N(N), .K(K), .B(B), .GPOLY(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .status    (status),
    .burst_pos (burst_pos)
`ifdef BURST_CODEC_STATS_EN
    ,
    .corr_cnt  (corr_cnt),
    .uncorr_cnt(uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // a(x) mod g(x) by long division
  function automatic logic [23:0] pmod(input logic [127:0] a_in);
    logic [127:0] a;
    logic [127:0] gw;
    a  = a_in;
    gw = {103'd0, G};
    for (int i = 127; i >= 24; i--)
      if (a[i]) a = a ^ (gw << (i - 24));
    return a[23:0];
  endfunction

  function automatic logic [63:0] model_encode(input logic [39:0] msg);
    logic [127:0] a;
    a = '0;
    a[63:24] = msg;
    return {msg, pmod(a)};
  endfunction

  // Finds the smallest j for which some nonzero e of degree < B gives e*x^j == s (mod g).
  task automatic model_decode(input logic [63:0] cw, output logic [63:0] d,
                              output logic [1:0] st, output logic [5:0] pos);
    logic [23:0]  s, acc;
    logic [7:0]   ev, fe;
    logic [127:0] ew;
    logic [63:0]  fixed;
    int           fj;
    bit           found;
    s     = pmod({64'd0, cw});
    d     = {24'd0, cw[63:24]};
    st    = 2'b00;
    pos   = '0;
    found = 1'b0;
    fj    = 0;
    fe    = '0;
    if (s != '0) begin
      for (int j = 0; j < N && !found; j++) begin
        for (int e = 1; e < 256 && !found; e++) begin
          ev  = e[7:0];
          acc = '0;
          for (int i = 0; i < B; i++) if (ev[i]) acc = acc ^ pw[j + i];
          if (acc == s) begin
            found = 1'b1;
            fj    = j;
            fe    = ev;
          end
        end
      end
      ew = {120'd0, fe} << fj;
      if (found && ew[127:64] == '0) begin
        fixed = cw ^ ew[63:0];
        d     = {24'd0, fixed[63:24]};
        st    = 2'b01;
        pos   = fj[5:0];
        if (m_corr < 16'hFFFF) m_corr++;
      end else begin
        st = 2'b10;
        if (m_uncorr < 16'hFFFF) m_uncorr++;
      end
    end
  endtask

  task automatic run_op(input logic [2:0] m, input logic [63:0] din, input bit now,
                        output logic [63:0] d, output logic [1:0] st,
                        output logic [5:0] pos, output int lat);
    if (!now) @(negedge clk);
    mode    = m;
    data_in = din;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mode  = 3'b000;
    lat   = 0;
    while (lat < TMO) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done === 1'b1) break;
    end
    d   = data_out;
    st  = status;
    pos = burst_pos;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    start   = 1'b1;
    mode    = 3'b001;
    data_in = {$urandom(), $urandom()};
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (data_out !== 64'd0) $display("FAIL reset_data: got %h want 0", data_out); else n_pass++;
    n_total++; if (status !== 2'b00) $display("FAIL reset_status: got %b want 00", status); else n_pass++;
    n_total++; if (burst_pos !== 6'd0) $display("FAIL reset_pos: got %0d want 0", burst_pos); else n_pass++;
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_no_accept: busy=%b done=%b want 0 0", busy, done); else n_pass++;
    m_corr   = 0;
    m_uncorr = 0;
  endtask

  task automatic test_encode_fixed();
    logic [63:0] d;
    logic [1:0]  st;
    logic [5:0]  pos;
    int          lat;
    cw_golden = model_encode(MSG0);
    run_op(3'b001, {24'd0, MSG0}, 1'b0, d, st, pos, lat);
    n_total++; if (lat !== ENC_LAT) $display("FAIL enc_latency: got %0d want %0d", lat, ENC_LAT); else n_pass++;
    n_total++; if (d[63:24] !== MSG0) $display("FAIL enc_msg: got %h want %h", d[63:24], MSG0); else n_pass++;
    n_total++; if (d !== cw_golden) $display("FAIL enc_codeword: got %h want %h", d, cw_golden); else n_pass++;
    n_total++; if (st !== 2'b00) $display("FAIL enc_status: got %b want 00", st); else n_pass++;
  endtask

  task automatic test_decode_fixed();
    logic [63:0] d, ed, cw;
    logic [1:0]  st, est;
    logic [5:0]  pos, epos;
    int          lat;
    model_decode(cw_golden, ed, est, epos);
    run_op(3'b010, cw_golden, 1'b0, d, st, pos, lat);
    n_total++; if (lat !== DEC_LAT) $display("FAIL dec_latency: got %0d want %0d", lat, DEC_LAT); else n_pass++;
    n_total++; if (d !== {24'd0, MSG0}) $display("FAIL dec_clean_data: got %h want %h", d, {24'd0, MSG0}); else n_pass++;
    n_total++; if (st !== 2'b00) $display("FAIL dec_clean_status: got %b want 00", st); else n_pass++;

    cw = cw_golden ^ (64'hFF << 56);
    model_decode(cw, ed, est, epos);
    run_op(3'b010, cw, 1'b0, d, st, pos, lat);
    n_total++; if (d !== {24'd0, MSG0}) $display("FAIL dec_burst_data: got %h want %h", d, {24'd0, MSG0}); else n_pass++;
    n_total++; if (st !== 2'b01) $display("FAIL dec_burst_status: got %b want 01", st); else n_pass++;
    n_total++; if (pos !== 6'd56) $display("FAIL dec_burst_pos: got %0d want 56", pos); else n_pass++;

    cw = cw_golden ^ (64'h1 | (64'h1 << 20));
    model_decode(cw, ed, est, epos);
    run_op(3'b010, cw, 1'b0, d, st, pos, lat);
    n_total++; if (d !== {24'd0, cw_golden[63:24]}) $display("FAIL dec_uncorr_data: got %h want %h", d, {24'd0, cw_golden[63:24]}); else n_pass++;
    n_total++; if (st !== est) $display("FAIL dec_uncorr_status: got %b want %b", st, est); else n_pass++;
    n_total++; if (pos !== epos) $display("FAIL dec_uncorr_pos: got %0d want %0d", pos, epos); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] r64, cw, err, d, ed;
    logic [39:0] msg;
    logic [7:0]  pat;
    logic [1:0]  st, est;
    logic [5:0]  pos, epos;
    int          lat, len, kind;
    for (int it = 0; it < 10; it++) begin
      r64 = {$urandom(), $urandom()};
      msg = r64[39:0];
      cw  = model_encode(msg);
      run_op(3'b001, {24'd0, msg}, 1'b0, d, st, pos, lat);
      n_total++; if (d !== cw || lat !== ENC_LAT)
        $display("FAIL rnd_enc[%0d]: got %h lat %0d want %h lat %0d", it, d, lat, cw, ENC_LAT); else n_pass++;
      kind = $urandom_range(0, 2);
      err  = '0;
      if (kind == 1) begin
        len = $urandom_range(1, B);
        pat = 8'($urandom()) & 8'((1 << len) - 1);
        pat[0] = 1'b1;
        pat[len-1] = 1'b1;
        err = {56'd0, pat} << $urandom_range(0, N - 1);
      end else if (kind == 2) begin
        err[$urandom_range(0, 31)] = 1'b1;
        err[$urandom_range(42, 63)] = 1'b1;
      end
      model_decode(cw ^ err, ed, est, epos);
      run_op(3'b010, cw ^ err, 1'b0, d, st, pos, lat);
      n_total++; if (d !== ed || st !== est || pos !== epos || lat !== DEC_LAT)
        $display("FAIL rnd_dec[%0d]: got %h/%b/%0d lat %0d want %h/%b/%0d lat %0d",
                 it, d, st, pos, lat, ed, est, epos, DEC_LAT); else n_pass++;
    end
  endtask

  task automatic test_protocol();
    logic [63:0] cw, ed, gd;
    logic [1:0]  est, gst;
    logic [5:0]  epos, gpos;
    bit          saw_busy;
    int          ndone, lat_first;
    // reserved and IDLE modes with start are ignored
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      mode    = (v == 0) ? 3'b011 : 3'b000;
      data_in = {$urandom(), $urandom()};
      start   = 1'b1;
      saw_busy = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0) saw_busy = 1'b1;
      end
      start = 1'b0;
      n_total++; if (saw_busy) $display("FAIL ignore_mode_%0d: busy/done seen, want none", v); else n_pass++;
    end
    // extra start pulses while busy
    cw = model_encode(40'h0123456789) ^ (64'h5B << 13);
    model_decode(cw, ed, est, epos);
    @(negedge clk);
    mode    = 3'b010;
    data_in = cw;
    start   = 1'b1;
    @(posedge clk);
    ndone = 0;
    lat_first = 0;
    gd = '0; gst = '0; gpos = '0;
    for (int c = 0; c <= DEC_LAT + 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          lat_first = c;
          gd = data_out; gst = status; gpos = burst_pos;
        end
      end
      start   = (c < DEC_LAT - 10) ? ($urandom_range(0, 1) == 1) : 1'b0;
      mode    = 3'($urandom_range(1, 2));
      data_in = {$urandom(), $urandom()};
    end
    start = 1'b0;
    mode  = 3'b000;
    n_total++; if (ndone !== 1) $display("FAIL busy_start_done_count: got %0d want 1", ndone); else n_pass++;
    n_total++; if (lat_first !== DEC_LAT) $display("FAIL busy_start_latency: got %0d want %0d", lat_first, DEC_LAT); else n_pass++;
    n_total++; if (gd !== ed || gst !== est || gpos !== epos)
      $display("FAIL busy_start_result: got %h/%b/%0d want %h/%b/%0d", gd, gst, gpos, ed, est, epos); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] d, ed, cw;
    logic [1:0]  st, est;
    logic [5:0]  pos, epos;
    int          lat;
    cw = model_encode(40'hA5A5F00F3C) ^ (64'h81 << 30);
    model_decode(cw, ed, est, epos);
    run_op(3'b010, cw, 1'b0, d, st, pos, lat);
    n_total++; if (d !== ed || st !== est || pos !== epos)
      $display("FAIL b2b_dec: got %h/%b/%0d want %h/%b/%0d", d, st, pos, ed, est, epos); else n_pass++;
    cw = model_encode(40'h13579BDF02);
    run_op(3'b001, 64'h13579BDF02, 1'b1, d, st, pos, lat);
    n_total++; if (lat !== ENC_LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, ENC_LAT); else n_pass++;
    n_total++; if (d !== cw) $display("FAIL b2b_enc: got %h want %h", d, cw); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d, cw;
    logic [1:0]  st;
    logic [5:0]  pos;
    int          lat;
    @(negedge clk);
    mode    = 3'b010;
    data_in = model_encode(40'hFEDCBA9876) ^ 64'h3;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mode  = 3'b000;
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_corr   = 0;
    m_uncorr = 0;
    n_total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midrst_ctrl: busy=%b done=%b want 0 0", busy, done); else n_pass++;
    n_total++; if (data_out !== 64'd0 || status !== 2'b00 || burst_pos !== 6'd0)
      $display("FAIL midrst_outputs: got %h/%b/%0d want 0/00/0", data_out, status, burst_pos); else n_pass++;
    cw = model_encode(40'h00C0FFEE11);
    run_op(3'b001, 64'h00C0FFEE11, 1'b0, d, st, pos, lat);
    n_total++; if (d !== cw || lat !== ENC_LAT)
      $display("FAIL midrst_enc: got %h lat %0d want %h lat %0d", d, lat, cw, ENC_LAT); else n_pass++;
  endtask

`ifdef BURST_CODEC_STATS_EN
  task automatic test_stats();
    logic [63:0] d, ed;
    logic [1:0]  st, est;
    logic [5:0]  pos, epos;
    int          lat;
    model_decode(cw_golden ^ (64'hFF << 56), ed, est, epos);
    run_op(3'b010, cw_golden ^ (64'hFF << 56), 1'b0, d, st, pos, lat);
    model_decode(cw_golden ^ (64'h1 | (64'h1 << 20)), ed, est, epos);
    run_op(3'b010, cw_golden ^ (64'h1 | (64'h1 << 20)), 1'b0, d, st, pos, lat);
    n_total++; if (corr_cnt !== 16'(m_corr)) $display("FAIL stats_corr: got %0d want %0d", corr_cnt, m_corr); else n_pass++;
    n_total++; if (uncorr_cnt !== 16'(m_uncorr)) $display("FAIL stats_uncorr: got %0d want %0d", uncorr_cnt, m_uncorr); else n_pass++;
  endtask
`endif

  initial begin
    for (int k = 0; k < 72; k++) pw[k] = pmod(128'd1 << k);
    cw_golden = '0;
    test_reset();
    test_encode_fixed();
    test_decode_fixed();
    test_random();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
`ifdef BURST_CODEC_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
